// File: rtl/bus_mailbox_target.sv
// ---------------------------------------------------------------------------
// bus_mailbox_target
//
// A CPU bus target that exposes an 8-word register window at BASE_ADDR. It
// holds two scratch registers, a free-running tick counter, and a 16 x 32
// first-word-fall-through FIFO that carries words from the CPU to a device.
//
// A bus cycle moves through IDLE -> WAIT -> ACK -> HOLD. The request is
// captured in IDLE. WAIT inserts WAIT_STATES extra cycles. The edge that
// closes ACK performs the access and raises a one-cycle ready pulse. HOLD
// waits for the strobe to drop before the next request can be accepted.
//
// Ports
//   i_clk            : sole clock, rising edge
//   i_rst            : asynchronous active-low reset
//   i_bus_clk        : CPU request strobe, high while a cycle is outstanding
//   i_bus_we         : 1 = write, 0 = read (sampled at capture)
//   i_bus_addr[31:0] : word address (sampled at capture)
//   i_bus_data[31:0] : write data (sampled at capture)
//   o_bus_data[31:0] : read data, non-zero only with o_bus_data_ready
//   o_bus_data_ready : one-cycle completion pulse
//   o_fifo_data[31:0]: FIFO head word
//   o_fifo_valid     : FIFO not empty
//   i_fifo_ready     : consumer accepts the head word
//
// Register map (word index)
//   0/1 SCRATCH0/1 R/W
//   2   FIFO_DATA  write pushes, read returns 0
//   3   STATUS     read {24'b0, count, overflow, full, empty};
//                  write bit0 flushes, bit1 clears overflow
//   4   TICK       read returns the counter, write clears it
//   5-7 reserved   read 0, writes ignored
// ---------------------------------------------------------------------------
module bus_mailbox_target #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_FF00,
  parameter int          WAIT_STATES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_bus_clk,
  input  logic        i_bus_we,
  input  logic [31:0] i_bus_addr,
  input  logic [31:0] i_bus_data,
  output logic [31:0] o_bus_data,
  output logic        o_bus_data_ready,
  output logic [31:0] o_fifo_data,
  output logic        o_fifo_valid,
  input  logic        i_fifo_ready
);

  localparam logic [3:0] WAIT_CNT_MAX = 4'(WAIT_STATES);
  localparam logic [4:0] FIFO_DEPTH   = 5'd16;

  localparam logic [2:0] IDX_SCRATCH0 = 3'd0;
  localparam logic [2:0] IDX_SCRATCH1 = 3'd1;
  localparam logic [2:0] IDX_FIFO     = 3'd2;
  localparam logic [2:0] IDX_STATUS   = 3'd3;
  localparam logic [2:0] IDX_TICK     = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t      state_r;
  logic        cap_we_r;
  logic [2:0]  cap_idx_r;
  logic [31:0] cap_data_r;
  logic [3:0]  wait_cnt_r;
  logic        bus_ready_r;
  logic [31:0] bus_data_r;
  logic [31:0] scratch0_r;
  logic [31:0] scratch1_r;
  logic [31:0] tick_r;

  logic [31:0] fifo_mem_r [16];
  logic [3:0]  wr_ptr_r;
  logic [3:0]  rd_ptr_r;
  logic [4:0]  count_r;
  logic        overflow_r;
  logic        fifo_valid_r;
  logic [31:0] fifo_data_r;

  logic        hit_s;
  logic        ack_s;
  logic        wr_fifo_s;
  logic        wr_status_s;
  logic        wr_tick_s;
  logic        flush_s;
  logic        clr_ovf_s;
  logic        full_s;
  logic        empty_s;
  logic        pop_s;
  logic        push_do_s;
  logic        ovf_set_s;
  logic [3:0]  wr_ptr_nx_s;
  logic [3:0]  rd_ptr_nx_s;
  logic [4:0]  count_nx_s;
  logic [31:0] head_nx_s;
  logic [31:0] status_s;
  logic [31:0] rd_mux_s;

  assign o_bus_data       = bus_data_r;
  assign o_bus_data_ready = bus_ready_r;
  assign o_fifo_data      = fifo_data_r;
  assign o_fifo_valid     = fifo_valid_r;

  assign hit_s       = (i_bus_addr[31:3] == BASE_ADDR[31:3]);
  // The access itself happens on the edge that closes the ACK state.
  assign ack_s       = (state_r == ST_ACK);
  assign wr_fifo_s   = ack_s & cap_we_r & (cap_idx_r == IDX_FIFO);
  assign wr_status_s = ack_s & cap_we_r & (cap_idx_r == IDX_STATUS);
  assign wr_tick_s   = ack_s & cap_we_r & (cap_idx_r == IDX_TICK);
  assign flush_s     = wr_status_s & cap_data_r[0];
  assign clr_ovf_s   = wr_status_s & cap_data_r[1];
  assign full_s      = (count_r == FIFO_DEPTH);
  assign empty_s     = (count_r == 5'd0);
  assign pop_s       = fifo_valid_r & i_fifo_ready;
  assign status_s    = {24'd0, count_r, overflow_r, full_s, empty_s};

  // Read data selection for the captured register index.
  always_comb begin
    rd_mux_s = 32'd0;
    case (cap_idx_r)
      IDX_SCRATCH0: rd_mux_s = scratch0_r;
      IDX_SCRATCH1: rd_mux_s = scratch1_r;
      IDX_FIFO:     rd_mux_s = 32'd0;
      IDX_STATUS:   rd_mux_s = status_s;
      IDX_TICK:     rd_mux_s = tick_r;
      default:      rd_mux_s = 32'd0;
    endcase
  end

  // FIFO next-state: flush beats pop; a full FIFO still accepts a push
  // when the same edge pops.
  always_comb begin
    push_do_s   = 1'b0;
    ovf_set_s   = 1'b0;
    wr_ptr_nx_s = wr_ptr_r;
    rd_ptr_nx_s = rd_ptr_r;
    count_nx_s  = count_r;
    if (flush_s) begin
      wr_ptr_nx_s = 4'd0;
      rd_ptr_nx_s = 4'd0;
      count_nx_s  = 5'd0;
    end else begin
      if (pop_s) begin
        rd_ptr_nx_s = rd_ptr_r + 4'd1;
      end else begin
        rd_ptr_nx_s = rd_ptr_r;
      end
      if (wr_fifo_s) begin
        if (!full_s || pop_s) begin
          push_do_s = 1'b1;
        end else begin
          ovf_set_s = 1'b1;
        end
      end else begin
        push_do_s = 1'b0;
      end
      if (push_do_s) begin
        wr_ptr_nx_s = wr_ptr_r + 4'd1;
      end else begin
        wr_ptr_nx_s = wr_ptr_r;
      end
      case ({push_do_s, pop_s})
        2'b10:   count_nx_s = count_r + 5'd1;
        2'b01:   count_nx_s = count_r - 5'd1;
        default: count_nx_s = count_r;
      endcase
    end
  end

  // Head word for the next cycle. A word pushed into the slot that becomes
  // the head is forwarded because the memory write lands on the same edge.
  always_comb begin
    head_nx_s = 32'd0;
    if (count_nx_s == 5'd0) begin
      head_nx_s = 32'd0;
    end else if (push_do_s && (wr_ptr_r == rd_ptr_nx_s)) begin
      head_nx_s = cap_data_r;
    end else begin
      head_nx_s = fifo_mem_r[rd_ptr_nx_s];
    end
  end

  // FIFO storage array. It has no reset; the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (push_do_s) begin
      fifo_mem_r[wr_ptr_r] <= cap_data_r;
    end
  end

  // FIFO pointers, occupancy, sticky overflow and the registered head.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_r     <= 4'd0;
      rd_ptr_r     <= 4'd0;
      count_r      <= 5'd0;
      overflow_r   <= 1'b0;
      fifo_valid_r <= 1'b0;
      fifo_data_r  <= 32'd0;
    end else begin
      wr_ptr_r     <= wr_ptr_nx_s;
      rd_ptr_r     <= rd_ptr_nx_s;
      count_r      <= count_nx_s;
      fifo_valid_r <= (count_nx_s != 5'd0);
      fifo_data_r  <= head_nx_s;
      if (clr_ovf_s) begin
        overflow_r <= 1'b0;
      end else if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  // Free-running cycle counter. A TICK write restarts it from zero.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tick_r <= 32'd0;
    end else if (wr_tick_s) begin
      tick_r <= 32'd0;
    end else begin
      tick_r <= tick_r + 32'd1;
    end
  end

  // Bus transaction FSM with registered ready and read data.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r     <= ST_IDLE;
      cap_we_r    <= 1'b0;
      cap_idx_r   <= 3'd0;
      cap_data_r  <= 32'd0;
      wait_cnt_r  <= 4'd0;
      bus_ready_r <= 1'b0;
      bus_data_r  <= 32'd0;
      scratch0_r  <= 32'd0;
      scratch1_r  <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          bus_ready_r <= 1'b0;
          bus_data_r  <= 32'd0;
          if (i_bus_clk && hit_s) begin
            cap_we_r   <= i_bus_we;
            cap_idx_r  <= i_bus_addr[2:0];
            cap_data_r <= i_bus_data;
            wait_cnt_r <= 4'd0;
            state_r    <= ST_WAIT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          // The strobe is ignored here, so a dropped request still completes.
          if (wait_cnt_r == WAIT_CNT_MAX) begin
            state_r <= ST_ACK;
          end else begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
          end
        end
        ST_ACK: begin
          bus_ready_r <= 1'b1;
          if (cap_we_r) begin
            bus_data_r <= 32'd0;
            if (cap_idx_r == IDX_SCRATCH0) begin
              scratch0_r <= cap_data_r;
            end else if (cap_idx_r == IDX_SCRATCH1) begin
              scratch1_r <= cap_data_r;
            end
          end else begin
            bus_data_r <= rd_mux_s;
          end
          state_r <= ST_HOLD;
        end
        ST_HOLD: begin
          bus_ready_r <= 1'b0;
          bus_data_r  <= 32'd0;
          if (!i_bus_clk) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          bus_ready_r <= 1'b0;
          bus_data_r  <= 32'd0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_mailbox_target.sv
// ---------------------------------------------------------------------------
// tb_bus_mailbox_target
//
// Directed and randomized bench for bus_mailbox_target. A behavioural model
// reproduces the visible behaviour of the target: the register set, the FIFO
// as a queue, and the completion timing (capture + WAIT_STATES + 2). Each
// clock step advances the model and compares every output with it. The
// directed steps also compare against fixed constants.
// ---------------------------------------------------------------------------
module tb_bus_mailbox_target;

  localparam logic [31:0] BASE = 32'h0000_FF00;
  localparam int          WS   = 1;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_bus_clk;
  logic        i_bus_we;
  logic [31:0] i_bus_addr;
  logic [31:0] i_bus_data;
  logic [31:0] o_bus_data;
  logic        o_bus_data_ready;
  logic [31:0] o_fifo_data;
  logic        o_fifo_valid;
  logic        i_fifo_ready;

  bus_mailbox_target #(.BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_bus_clk        (i_bus_clk),
    .i_bus_we         (i_bus_we),
    .i_bus_addr       (i_bus_addr),
    .i_bus_data       (i_bus_data),
    .o_bus_data       (o_bus_data),
    .o_bus_data_ready (o_bus_data_ready),
    .o_fifo_data      (o_fifo_data),
    .o_fifo_valid     (o_fifo_valid),
    .i_fifo_ready     (i_fifo_ready)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  bit rand_rdy = 1'b0;

  // Reference model state
  logic [31:0] m_scratch [2];
  logic [31:0] m_q [$];
  logic        m_ovf;
  logic [31:0] m_tick;
  int          m_phase;   // 0 idle, 1 request pending, 2 waiting for strobe low
  int          m_cyc;
  int          m_act_at;
  logic        m_we;
  logic [2:0]  m_idx;
  logic [31:0] m_data;
  logic        m_ready;
  logic [31:0] m_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_scratch[0] = 32'd0;
    m_scratch[1] = 32'd0;
    m_q.delete();
    m_ovf   = 1'b0;
    m_tick  = 32'd0;
    m_phase = 0;
    m_ready = 1'b0;
    m_rdata = 32'd0;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] idx);
    logic [4:0] cnt;
    cnt = 5'(m_q.size());
    case (idx)
      3'd0:    return m_scratch[0];
      3'd1:    return m_scratch[1];
      3'd3:    return {24'd0, cnt, m_ovf, (m_q.size() == 16), (m_q.size() == 0)};
      3'd4:    return m_tick;
      default: return 32'd0;
    endcase
  endfunction

  // Apply the effect of the coming rising edge, using the inputs that are
  // held across it.
  task automatic model_edge();
    bit act;
    bit popped;
    if (!i_rst) return;
    m_cyc++;
    m_ready = 1'b0;
    m_rdata = 32'd0;
    act    = (m_phase == 1) && (m_cyc == m_act_at);
    popped = (m_q.size() != 0) && i_fifo_ready;
    if (act) begin
      m_ready = 1'b1;
      if (!m_we) m_rdata = model_read(m_idx);
    end
    if (act && m_we && m_idx == 3'd3 && m_data[0]) begin
      m_q.delete();
    end else begin
      if (popped) void'(m_q.pop_front());
      if (act && m_we && m_idx == 3'd2) begin
        if (m_q.size() < 16) m_q.push_back(m_data);
        else m_ovf = 1'b1;
      end
    end
    if (act && m_we && m_idx == 3'd3 && m_data[1]) m_ovf = 1'b0;
    if (act && m_we && m_idx < 3'd2) m_scratch[m_idx[0]] = m_data;
    m_tick = (act && m_we && m_idx == 3'd4) ? 32'd0 : m_tick + 32'd1;
    if (m_phase == 0) begin
      if (i_bus_clk && (i_bus_addr[31:3] == BASE[31:3])) begin
        m_we     = i_bus_we;
        m_idx    = i_bus_addr[2:0];
        m_data   = i_bus_data;
        m_act_at = m_cyc + WS + 2;
        m_phase  = 1;
      end
    end else if (act) begin
      m_phase = 2;
    end else if (m_phase == 2 && !i_bus_clk) begin
      m_phase = 0;
    end
  endtask

  task automatic check_outputs();
    check("ready", {31'd0, o_bus_data_ready}, {31'd0, m_ready});
    check("rdata", o_bus_data, m_rdata);
    check("fifo_valid", {31'd0, o_fifo_valid}, {31'd0, (m_q.size() != 0)});
    if (m_q.size() != 0) check("fifo_data", o_fifo_data, m_q[0]);
    else if (!i_rst) check("fifo_data_rst", o_fifo_data, 32'd0);
  endtask

  // One clock: model the edge, let it happen, then compare at the falling edge.
  task automatic step();
    if (rand_rdy) i_fifo_ready = 1'($urandom_range(0, 1));
    model_edge();
    @(posedge i_clk);
    @(negedge i_clk);
    check_outputs();
  endtask

  task automatic bus_xfer(input logic we, input logic [2:0] idx, input logic [31:0] data,
                          input bit drop_early, input bit pop_on_ack,
                          output logic [31:0] rdata);
    int lat;
    i_bus_clk  = 1'b1;
    i_bus_we   = we;
    i_bus_addr = BASE | {29'd0, idx};
    i_bus_data = data;
    step();                                   // capture edge
    if (drop_early) i_bus_clk = 1'b0;
    lat = 0;
    while (o_bus_data_ready !== 1'b1 && lat < 40) begin
      if (pop_on_ack) i_fifo_ready = (lat == WS + 1);
      step();
      lat++;
    end
    rdata = o_bus_data;
    check("latency", 32'(lat), 32'(WS + 2));
    if (pop_on_ack) i_fifo_ready = 1'b0;
    i_bus_clk = 1'b0;
    step();
  endtask

  task automatic bus_miss(input logic [31:0] addr, input int cycles);
    int pulses;
    pulses     = 0;
    i_bus_clk  = 1'b1;
    i_bus_we   = 1'($urandom_range(0, 1));
    i_bus_addr = addr;
    i_bus_data = $urandom;
    repeat (cycles) begin
      step();
      if (o_bus_data_ready === 1'b1) pulses++;
    end
    check("miss_no_ready", 32'(pulses), 32'd0);
    i_bus_clk = 1'b0;
    step();
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    int          op;

    i_rst = 1'b0; i_bus_clk = 1'b0; i_bus_we = 1'b0;
    i_bus_addr = 32'd0; i_bus_data = 32'd0; i_fifo_ready = 1'b0;
    m_cyc = 0; m_act_at = 0; m_we = 1'b0; m_idx = 3'd0; m_data = 32'd0;
    model_reset();

    // Reset state
    repeat (3) step();
    check("rst_ready", {31'd0, o_bus_data_ready}, 32'd0);
    check("rst_fifo_data", o_fifo_data, 32'd0);
    i_rst = 1'b1;
    step();

    // SCRATCH0 write then read back
    bus_xfer(1'b1, 3'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, rd);
    bus_xfer(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, rd);
    check("scratch0_rd", rd, 32'hDEAD_BEEF);

    // Miss one word beyond the window
    bus_miss(BASE + 32'd8, 20);
    bus_xfer(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, rd);
    check("after_miss_rd", rd, 32'hDEAD_BEEF);

    // Overflow: 17 pushes into a FIFO nobody drains
    for (int i = 0; i < 17; i++) bus_xfer(1'b1, 3'd2, 32'h100 + 32'(i), 1'b0, 1'b0, rd);
    bus_xfer(1'b0, 3'd3, 32'd0, 1'b0, 1'b0, rd);
    check("status_ovf", rd, 32'h0000_0086);
    bus_xfer(1'b1, 3'd3, 32'h2, 1'b0, 1'b0, rd);
    bus_xfer(1'b0, 3'd3, 32'd0, 1'b0, 1'b0, rd);
    check("status_clr", rd, 32'h0000_0082);

    // Push and pop on the same edge at full, then flush while draining
    bus_xfer(1'b1, 3'd2, 32'hCAFE_0001, 1'b0, 1'b1, rd);
    bus_xfer(1'b0, 3'd3, 32'd0, 1'b0, 1'b0, rd);
    check("status_full_pp", rd, 32'h0000_0082);
    i_fifo_ready = 1'b1;
    bus_xfer(1'b1, 3'd3, 32'h1, 1'b0, 1'b0, rd);
    bus_xfer(1'b0, 3'd3, 32'd0, 1'b0, 1'b0, rd);
    check("status_flushed", rd, 32'h0000_0001);
    i_fifo_ready = 1'b0;

    // FWFT drain order
    bus_xfer(1'b1, 3'd2, 32'd1, 1'b0, 1'b0, rd);
    bus_xfer(1'b1, 3'd2, 32'd2, 1'b0, 1'b0, rd);
    bus_xfer(1'b1, 3'd2, 32'd3, 1'b0, 1'b0, rd);
    check("head1", o_fifo_data, 32'd1);
    i_fifo_ready = 1'b1;
    step();
    check("head2", o_fifo_data, 32'd2);
    step();
    check("head3", o_fifo_data, 32'd3);
    step();
    check("drained_valid", {31'd0, o_fifo_valid}, 32'd0);
    bus_xfer(1'b0, 3'd3, 32'd0, 1'b0, 1'b0, rd);
    check("status_empty", rd, 32'h0000_0001);
    i_fifo_ready = 1'b0;

    // TICK clear then read: one idle edge, capture, then WS+2 edges
    bus_xfer(1'b1, 3'd4, 32'h1234, 1'b0, 1'b0, rd);
    bus_xfer(1'b0, 3'd4, 32'd0, 1'b0, 1'b0, rd);
    check("tick_rd", rd, 32'(WS + 3));

    // Strobe dropped during WAIT still completes
    bus_xfer(1'b1, 3'd1, 32'h5A5A_0001, 1'b1, 1'b0, rd);
    bus_xfer(1'b0, 3'd1, 32'd0, 1'b0, 1'b0, rd);
    check("drop_early_wr", rd, 32'h5A5A_0001);

    // Reset during WAIT aborts; a request held across release is new
    bus_xfer(1'b1, 3'd0, 32'h1234_5678, 1'b0, 1'b0, rd);
    i_bus_clk = 1'b1; i_bus_we = 1'b1; i_bus_addr = BASE; i_bus_data = 32'hAAAA_5555;
    step();
    i_rst = 1'b0;
    model_reset();
    #1;
    check("rst_mid_ready", {31'd0, o_bus_data_ready}, 32'd0);
    check("rst_mid_valid", {31'd0, o_fifo_valid}, 32'd0);
    i_bus_clk = 1'b0;
    @(negedge i_clk);
    check_outputs();
    step();
    i_bus_clk = 1'b1; i_bus_we = 1'b0; i_bus_addr = BASE;
    i_rst = 1'b1;
    bus_xfer(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, rd);
    check("scratch0_after_rst", rd, 32'd0);

    // Randomized traffic against the model
    rand_rdy = 1'b1;
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 7);
      case (op)
        0: bus_xfer(1'b1, 3'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0), 1'b0, rd);
        1: bus_xfer(1'b0, 3'($urandom_range(0, 7)), 32'd0, 1'($urandom_range(0, 3) == 0), 1'b0, rd);
        2, 3: bus_xfer(1'b1, 3'd2, $urandom, 1'b0, 1'b0, rd);
        4: bus_xfer(1'b0, 3'd3, 32'd0, 1'b0, 1'b0, rd);
        5: bus_xfer(1'b1, 3'(op + $urandom_range(0, 1) * 2 - 2), $urandom, 1'b0, 1'b0, rd);
        6: bus_xfer(1'($urandom_range(0, 1)), 3'd4, $urandom, 1'b0, 1'b0, rd);
        default: begin
          a = $urandom;
          if (a[31:3] == BASE[31:3]) a[3] = ~a[3];
          bus_miss(a, 3);
        end
      endcase
    end
    rand_rdy = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
